// File: rtl/vc_rr_arbiter.sv
// Weighted round-robin read scheduler for two virtual-channel FIFOs.
// Issues VC read strobes, captures returned words and forwards them as one stream.
module vc_rr_arbiter #(
    parameter int unsigned BITNUMBER = 6,
    parameter int unsigned BURST     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic                 vc0_valid,
    input  logic                 vc1_valid,
    input  logic [BITNUMBER-1:0] vc0_data,
    input  logic [BITNUMBER-1:0] vc1_data,
    input  logic                 pause,
    output logic                 vc0_rd,
    output logic                 vc1_rd,
    output logic [BITNUMBER-1:0] arb_data_out,
    output logic                 arb_valid,
    output logic                 arb_vc,
    output logic [1:0]           arb_state,
    output logic                 arb_error
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StServe0 = 2'b01,
        StServe1 = 2'b10
    } state_e;

    localparam logic [2:0] BurstMax = 3'(BURST - 1);

    state_e     state_q;
    logic [2:0] burst_cnt_q;
    logic       last_vc_q;
    logic       out0_q;
    logic       out1_q;
    logic       flush_q;

    logic       serve_vc;
    logic       other_empty;
    state_e     other_state;
    logic       rd_any;

    always_comb begin
        vc0_rd = 1'b0;
        vc1_rd = 1'b0;
        if (reset && !pause) begin
            vc0_rd = (state_q == StServe0) && !vc0_empty;
            vc1_rd = (state_q == StServe1) && !vc1_empty;
        end
    end

    always_comb begin
        serve_vc    = (state_q == StServe1);
        other_empty = serve_vc ? vc0_empty : vc1_empty;
        other_state = serve_vc ? StServe0 : StServe1;
        rd_any      = vc0_rd | vc1_rd;
    end

    assign arb_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            burst_cnt_q <= 3'd0;
            last_vc_q   <= 1'b1;
        end else if (!pause) begin
            unique case (state_q)
                StIdle: begin
                    burst_cnt_q <= 3'd0;
                    if (!vc0_empty && !vc1_empty) begin
                        state_q <= last_vc_q ? StServe0 : StServe1;
                    end else if (!vc0_empty) begin
                        state_q <= StServe0;
                    end else if (!vc1_empty) begin
                        state_q <= StServe1;
                    end
                end
                StServe0, StServe1: begin
                    if (rd_any) begin
                        if (burst_cnt_q < BurstMax) begin
                            burst_cnt_q <= burst_cnt_q + 3'd1;
                        end else begin
                            // Burst done: rotate if the other VC has work, else start a fresh burst
                            last_vc_q   <= serve_vc;
                            burst_cnt_q <= 3'd0;
                            if (!other_empty) state_q <= other_state;
                        end
                    end else begin
                        last_vc_q   <= serve_vc;
                        burst_cnt_q <= 3'd0;
                        state_q     <= other_empty ? StIdle : other_state;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // flush_q drops any valid belonging to a read issued before the last reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_data_out <= '0;
            arb_valid    <= 1'b0;
            arb_vc       <= 1'b0;
            arb_error    <= 1'b0;
            out0_q       <= 1'b0;
            out1_q       <= 1'b0;
            flush_q      <= 1'b1;
        end else begin
            flush_q <= 1'b0;
            out0_q  <= vc0_rd;
            out1_q  <= vc1_rd;
            if (flush_q) begin
                arb_valid <= 1'b0;
            end else if (vc0_valid) begin
                arb_data_out <= vc0_data;
                arb_vc       <= 1'b0;
                arb_valid    <= 1'b1;
            end else if (vc1_valid) begin
                arb_data_out <= vc1_data;
                arb_vc       <= 1'b1;
                arb_valid    <= 1'b1;
            end else begin
                arb_valid <= 1'b0;
            end
            if (!flush_q && ((vc0_valid && !out0_q) || (vc1_valid && !out1_q) ||
                             (vc0_valid && vc1_valid))) begin
                arb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Self-checking bench for vc_rr_arbiter: bench-side VC FIFOs plus a rule-level arbiter model.
module tb_vc_rr_arbiter;

    localparam int BW    = 6;
    localparam int BURST = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vc0_empty = 1'b1, vc1_empty = 1'b1;
    logic          vc0_valid = 1'b0, vc1_valid = 1'b0;
    logic [BW-1:0] vc0_data = '0, vc1_data = '0;
    logic          pause = 1'b0;
    logic          vc0_rd, vc1_rd, arb_valid, arb_vc, arb_error;
    logic [BW-1:0] arb_data_out;
    logic [1:0]    arb_state;

    vc_rr_arbiter #(.BITNUMBER(BW), .BURST(BURST)) dut (
        .clk(clk), .reset(reset),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_valid(vc0_valid), .vc1_valid(vc1_valid),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .pause(pause),
        .vc0_rd(vc0_rd), .vc1_rd(vc1_rd),
        .arb_data_out(arb_data_out), .arb_valid(arb_valid), .arb_vc(arb_vc),
        .arb_state(arb_state), .arb_error(arb_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bench-side VC FIFO contents and their read-return pipeline
    logic [BW-1:0] q0[$], q1[$];
    bit            nv0, nv1;
    logic [BW-1:0] nd0, nd1;
    bit            pause_ctl;

    // Rule-level model of the arbiter
    int            m_state, m_cnt, m_last;
    bit            m_valid, m_vc, m_err, m_out0, m_out1, m_flush;
    logic [BW-1:0] m_data;

    // Observations from the last step
    int seen_state;
    bit seen_valid, seen_vc, seen_err, seen_rd0, seen_rd1;
    int rd_log[$], vc_log[$];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_last = 1;
        m_valid = 0; m_vc = 0; m_data = '0; m_err = 0;
        m_out0 = 0; m_out1 = 0; m_flush = 1;
    endtask

    task automatic step(input bit do_rst, input bit inj1);
        bit ne0, ne1, er0, er1, own, oth;
        int x;
        @(negedge clk);
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_valid = nv0;
        vc0_data  = nd0;
        vc1_valid = nv1 | inj1;
        vc1_data  = inj1 ? BW'($urandom) : nd1;
        pause     = pause_ctl;
        if (do_rst) begin
            reset = 1'b0;
            #1;
            chk("rst_state", arb_state, 0);
            chk("rst_rd", {vc1_rd, vc0_rd}, 0);
            chk("rst_valid", arb_valid, 0);
            chk("rst_data", arb_data_out, 0);
            chk("rst_vc", arb_vc, 0);
            chk("rst_err", arb_error, 0);
            model_reset();
            reset = 1'b1;
        end
        #1;
        ne0 = !vc0_empty;
        ne1 = !vc1_empty;
        er0 = (m_state == 1) && ne0 && !pause;
        er1 = (m_state == 2) && ne1 && !pause;
        chk("rd0", vc0_rd, er0);
        chk("rd1", vc1_rd, er1);
        chk("state", arb_state, m_state);
        chk("valid", arb_valid, m_valid);
        chk("vc", arb_vc, m_vc);
        chk("data", arb_data_out, m_data);
        chk("error", arb_error, m_err);
        seen_state = arb_state; seen_valid = arb_valid; seen_vc = arb_vc;
        seen_err = arb_error; seen_rd0 = vc0_rd; seen_rd1 = vc1_rd;
        if (vc0_rd) rd_log.push_back(0);
        if (vc1_rd) rd_log.push_back(1);
        if (arb_valid) vc_log.push_back(arb_vc);

        // FIFO returns a popped word one cycle after the read
        nv0 = er0;
        if (er0) nd0 = q0.pop_front();
        nv1 = er1;
        if (er1) nd1 = q1.pop_front();

        if (m_flush) m_valid = 0;
        else if (vc0_valid) begin m_data = vc0_data; m_vc = 0; m_valid = 1; end
        else if (vc1_valid) begin m_data = vc1_data; m_vc = 1; m_valid = 1; end
        else m_valid = 0;
        if (!m_flush && ((vc0_valid && !m_out0) || (vc1_valid && !m_out1) ||
                         (vc0_valid && vc1_valid))) m_err = 1;
        m_flush = 0;
        m_out0 = er0;
        m_out1 = er1;

        if (!pause) begin
            if (m_state == 0) begin
                m_cnt = 0;
                if (ne0 && ne1) m_state = (m_last == 1) ? 1 : 2;
                else if (ne0) m_state = 1;
                else if (ne1) m_state = 2;
            end else begin
                x   = m_state - 1;
                own = x ? ne1 : ne0;
                oth = x ? ne0 : ne1;
                if (own) begin
                    if (m_cnt < BURST - 1) m_cnt++;
                    else begin
                        m_last = x; m_cnt = 0;
                        if (oth) m_state = 2 - x;
                    end
                end else begin
                    m_last = x; m_cnt = 0;
                    m_state = oth ? 2 - x : 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && m_state == 0 && !nv0 && !nv1 && !m_valid) begin
                done = 1;
                break;
            end
            step(0, 0);
        end
        step(0, 0);
        chk("drain_timeout", done, 1);
    endtask

    initial begin
        int first, last, n, extra;
        int exp_order[8];
        nv0 = 0; nv1 = 0; nd0 = '0; nd1 = '0; pause_ctl = 0;
        model_reset();
        repeat (2) @(posedge clk);
        step(1, 0);
        step(0, 0);

        // VC0 alone, 5 words: back-to-back reads, then idle
        for (int i = 0; i < 5; i++) q0.push_back(BW'($urandom));
        n = 0; first = -1; last = -1; vc_log.delete();
        for (int i = 0; i < 20; i++) begin
            step(0, 0);
            if (seen_rd0) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        drain();
        chk("s2_rd_count", n, 5);
        chk("s2_consecutive", last - first + 1, 5);
        chk("s2_words_out", vc_log.size(), 5);
        chk("s2_idle", seen_state, 0);

        // Reset mid-burst (SERVE0 with one read done)
        for (int i = 0; i < 4; i++) q0.push_back(BW'($urandom));
        for (int i = 0; i < 10 && !(m_state == 1 && m_cnt == 1); i++) step(0, 0);
        chk("s1_reached", (m_state == 1 && m_cnt == 1) ? 1 : 0, 1);
        step(1, 0);
        drain();
        chk("s1_no_error", seen_err, 0);

        // Both VCs with 4 words from a fresh reset: 0,0,1,1,0,0,1,1
        step(1, 0);
        exp_order = '{0, 0, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            q0.push_back(BW'($urandom));
            q1.push_back(BW'($urandom));
        end
        rd_log.delete(); vc_log.delete();
        drain();
        chk("s3_rd_count", rd_log.size(), 8);
        chk("s3_vc_count", vc_log.size(), 8);
        for (int i = 0; i < 8 && i < rd_log.size() && i < vc_log.size(); i++) begin
            chk("s3_rd_order", rd_log[i], exp_order[i]);
            chk("s3_vc_order", vc_log[i], exp_order[i]);
        end

        // Pause 3 cycles during SERVE1
        for (int i = 0; i < 6; i++) q1.push_back(BW'($urandom));
        vc_log.delete();
        for (int i = 0; i < 10 && !seen_rd1; i++) step(0, 0);
        chk("s4_serving", seen_rd1, 1);
        pause_ctl = 1;
        n = 0; extra = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            if (seen_rd1 || seen_rd0) n++;
            if (i > 0 && seen_valid) extra++;
        end
        pause_ctl = 0;
        step(0, 0);
        if (seen_valid) extra++;
        chk("s4_rd_in_pause", n, 0);
        chk("s4_extra_le1", (extra <= 1) ? 1 : 0, 1);
        drain();
        chk("s4_no_loss", vc_log.size(), 6);

        // VC1 empties after one word of its burst: switch to SERVE0
        q1.push_back(BW'($urandom));
        for (int i = 0; i < 10 && seen_state != 2; i++) step(0, 0);
        chk("s5_in_serve1", seen_state, 2);
        for (int i = 0; i < 3; i++) q0.push_back(BW'($urandom));
        step(0, 0);
        step(0, 0);
        chk("s5_switch", seen_state, 1);
        drain();

        // Unsolicited vc1_valid: sticky error until reset
        step(0, 1);
        step(0, 0);
        chk("s6_err_set", seen_err, 1);
        chk("s6_forward_valid", seen_valid, 1);
        chk("s6_forward_vc", seen_vc, 1);
        repeat (5) step(0, 0);
        chk("s6_err_sticky", seen_err, 1);
        step(1, 0);
        chk("s6_err_cleared", seen_err, 0);

        // Randomised traffic with random back-pressure
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 8) q0.push_back(BW'($urandom));
            if ($urandom_range(0, 3) == 0 && q1.size() < 8) q1.push_back(BW'($urandom));
            pause_ctl = ($urandom_range(0, 4) == 0);
            step(0, 0);
        end
        pause_ctl = 0;
        drain();
        chk("rand_no_error", seen_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
